// File: rtl/jtag_seq_ctrl.sv
// JTAG scan sequencer: loads instruction/data FIFOs for the shift engine,
// launches IR and/or DR scans and tracks engine busy through to done/err.
module jtag_seq_ctrl #(
  parameter int DATA_INSTRUCTION = 10,
  parameter int DATA_FIFO        = 8,
  parameter int FIFO_DEPTH       = 16,
  parameter int MAX_WORDS        = 16,
  parameter int BUSY_TIMEOUT     = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [1:0]                        mode,
  input  logic [DATA_INSTRUCTION-1:0]       ir_value,
  input  logic [$clog2(MAX_WORDS+1)-1:0]    dr_words,
  input  logic [DATA_FIFO-1:0]              src_data,
  input  logic                              src_valid,
  output logic                              src_ready,
  output logic                              ready,
  output logic                              done,
  output logic                              err,
  output logic                              op,
  output logic                              work,
  input  logic                              busy,
  output logic [DATA_INSTRUCTION-1:0]       wdata_instruction,
  output logic                              wr_instruction,
  input  logic                              full_instruction,
  input  logic [$clog2(FIFO_DEPTH)-1:0]     usedw_instruction,
  output logic [DATA_FIFO-1:0]              wdata_data,
  output logic                              wr_data,
  input  logic                              full_data,
  input  logic [$clog2(FIFO_DEPTH)-1:0]     usedw_data
);

  // state         | meaning
  // ST_IDLE       | ready, waiting for start
  // ST_WR_IR      | write latched instruction into instruction FIFO
  // ST_WAIT_SPACE | wait until the whole DR burst fits in the data FIFO
  // ST_WR_DATA    | stream dr_words upstream words into the data FIFO
  // ST_LAUNCH     | pulse work once engine idle and no FIFO strobe active
  // ST_WAIT_BUSY  | wait for busy to rise, bounded by timeout
  // ST_WAIT_DONE  | wait for busy to fall, chain DR after IR in mode 10
  // ST_DONE       | one-cycle done (and err) pulse

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int UW = $clog2(FIFO_DEPTH);
  localparam int FW = UW + 1;
  localparam int SW = (FW > CW) ? FW : CW;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_IR,
    ST_WAIT_SPACE,
    ST_WR_DATA,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_DONE
  } state_t;

  state_t                      state, state_n;
  logic [1:0]                  mode_q;
  logic [DATA_INSTRUCTION-1:0] ir_q;
  logic [CW-1:0]               dr_q;
  logic [CW-1:0]               remaining;
  logic [TW-1:0]               tmo_cnt;
  logic                        err_q;

  logic [SW-1:0] free_words;
  logic [SW-1:0] need_words;
  logic          cmd_bad;
  logic          xfer;
  logic          load_cmd;
  logic          load_rem;
  logic          load_tmo;
  logic          set_err;
  logic          op_ld;
  logic          op_val;
  logic          unused_usedw;

  assign unused_usedw      = ^usedw_instruction;
  assign wdata_instruction = ir_q;

  assign free_words = full_data ? '0 : (SW'(FIFO_DEPTH) - SW'(usedw_data));
  assign need_words = SW'(dr_q);
  assign cmd_bad    = (mode == 2'b11) ||
                      ((mode != 2'b00) && (dr_words == '0)) ||
                      (dr_words > CW'(MAX_WORDS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mode_q     <= '0;
      ir_q       <= '0;
      dr_q       <= '0;
      remaining  <= '0;
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
      op         <= 1'b0;
      wr_data    <= 1'b0;
      wdata_data <= '0;
    end else begin
      state   <= state_n;
      wr_data <= xfer;
      if (xfer) begin
        wdata_data <= src_data;
        remaining  <= remaining - 1'b1;
      end
      if (load_cmd) begin
        mode_q <= mode;
        ir_q   <= ir_value;
        dr_q   <= dr_words;
        err_q  <= 1'b0;
      end
      if (set_err) err_q <= 1'b1;
      if (load_rem) remaining <= dr_q;
      if (op_ld) op <= op_val;
      // timeout window covers BUSY_TIMEOUT cycles after the work pulse
      if (load_tmo) tmo_cnt <= TW'(BUSY_TIMEOUT - 1);
      else if ((state == ST_WAIT_BUSY) && (tmo_cnt != '0)) tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  always_comb begin
    state_n        = state;
    ready          = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    work           = 1'b0;
    src_ready      = 1'b0;
    wr_instruction = 1'b0;
    xfer           = 1'b0;
    load_cmd       = 1'b0;
    load_rem       = 1'b0;
    load_tmo       = 1'b0;
    set_err        = 1'b0;
    op_ld          = 1'b0;
    op_val         = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          load_cmd = 1'b1;
          if (cmd_bad) begin
            set_err = 1'b1;
            state_n = ST_DONE;
          end else if (mode == 2'b01) begin
            state_n = ST_WAIT_SPACE;
          end else begin
            state_n = ST_WR_IR;
          end
        end
      end
      ST_WR_IR: begin
        if (!full_instruction) begin
          wr_instruction = 1'b1;
          op_ld          = 1'b1;
          op_val         = 1'b0;
          state_n        = ST_LAUNCH;
        end
      end
      ST_WAIT_SPACE: begin
        if (free_words >= need_words) begin
          op_ld    = 1'b1;
          op_val   = 1'b1;
          load_rem = 1'b1;
          state_n  = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        src_ready = (remaining != '0);
        xfer      = src_valid && src_ready;
        if (xfer && (remaining == CW'(1))) state_n = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        // the last data word is still being written on the first LAUNCH cycle
        if (!busy && !wr_data) begin
          work     = 1'b1;
          load_tmo = 1'b1;
          state_n  = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (busy) begin
          state_n = ST_WAIT_DONE;
        end else if (tmo_cnt == '0) begin
          set_err = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy) begin
          if ((mode_q == 2'b10) && !op) state_n = ST_WAIT_SPACE;
          else                          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtag_seq_ctrl.sv
// Directed bench for jtag_seq_ctrl with a small engine model and a
// negedge monitor that logs strobes, pulses and their cycle numbers.
module tb_jtag_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [9:0] ir_value;
  logic [4:0] dr_words;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic       ready, done, err, op, work;
  logic       busy;
  logic [9:0] wdata_instruction;
  logic       wr_instruction;
  logic       full_instruction;
  logic [3:0] usedw_instruction;
  logic [7:0] wdata_data;
  logic       wr_data;
  logic       full_data;
  logic [3:0] usedw_data;

  jtag_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .ir_value(ir_value),
    .dr_words(dr_words), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .ready(ready), .done(done), .err(err), .op(op),
    .work(work), .busy(busy), .wdata_instruction(wdata_instruction),
    .wr_instruction(wr_instruction), .full_instruction(full_instruction),
    .usedw_instruction(usedw_instruction), .wdata_data(wdata_data),
    .wr_data(wr_data), .full_data(full_data), .usedw_data(usedw_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0;
  int n_work, n_done, n_err, n_err_alone, n_wr_ir, n_wr_data, n_overlap, n_src_ready, n_op_bad;
  int work_cyc, done_cyc, fall_cyc, last_wrd_cyc;
  logic [9:0] last_ir;
  logic [7:0] dr_log [16];
  logic       op_at_work [4];
  logic       busy_prev = 1'b0;

  bit eng_en  = 1'b1;
  int eng_len = 5;
  int eng_left = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    n_work = 0; n_done = 0; n_err = 0; n_err_alone = 0; n_wr_ir = 0; n_wr_data = 0;
    n_overlap = 0; n_src_ready = 0; n_op_bad = 0;
    work_cyc = 0; done_cyc = 0; fall_cyc = 0; last_wrd_cyc = 0; last_ir = '0;
  endtask

  task automatic wait_done(input int prev, input int budget);
    int k = 0;
    while (n_done == prev && k < budget) begin
      tick(1);
      k++;
    end
    chk("done_seen", 32'(n_done != prev), 1);
    tick(2);
  endtask

  task automatic src_send(input logic [7:0] w, input int gap);
    bit hs = 1'b0;
    int k = 0;
    if (gap > 0) begin
      src_valid = 1'b0;
      tick(gap);
    end
    src_data  = w;
    src_valid = 1'b1;
    while (!hs && k < 300) begin
      @(negedge clk);
      hs = src_ready;
      @(posedge clk);
      #1;
      k++;
    end
    chk("src_accept", 32'(hs), 1);
  endtask

  task automatic cmd(input logic [1:0] m, input logic [9:0] ir, input logic [4:0] n);
    mode = m; ir_value = ir; dr_words = n; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (work) begin
      if (n_work < 4) op_at_work[n_work] = op;
      n_work++;
      work_cyc = cyc;
      if (wr_data || wr_instruction) n_overlap++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      if (err) n_err++;
    end
    if (err && !done) n_err_alone++;
    if (wr_instruction) begin
      n_wr_ir++;
      last_ir = wdata_instruction;
    end
    if (wr_data) begin
      if (n_wr_data < 16) dr_log[n_wr_data] = wdata_data;
      n_wr_data++;
      last_wrd_cyc = cyc;
      if (!op) n_op_bad++;
    end
    if (src_ready) n_src_ready++;
    if (busy_prev && !busy) fall_cyc = cyc;
    busy_prev = busy;
    if (work && eng_en) eng_left = eng_len;
  end

  // engine: busy high for eng_len cycles starting the cycle after work
  always @(posedge clk) begin
    #2;
    busy = (eng_left > 0);
    if (eng_left > 0) eng_left--;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  logic [1:0] bad_mode [3] = '{2'd1, 2'd3, 2'd2};
  logic [4:0] bad_dr   [3] = '{5'd0, 5'd4, 5'd17};

  initial begin
    rst = 1'b1; start = 1'b0; mode = '0; ir_value = '0; dr_words = '0;
    src_data = '0; src_valid = 1'b0; busy = 1'b0;
    full_instruction = 1'b0; usedw_instruction = '0; full_data = 1'b0; usedw_data = '0;
    clear_mon();
    tick(3);
    rst = 1'b0;

    chk("rst_ready", 32'(ready), 1);
    chk("rst_outs", {26'd0, done, err, op, work, wr_instruction, wr_data}, 0);
    chk("rst_wdata", {14'd0, wdata_instruction, wdata_data}, 0);
    chk("rst_src_ready", 32'(src_ready), 0);

    // IR only, fastest path
    clear_mon();
    eng_len = 5;
    cmd(2'b00, 10'h220, 5'd0);
    chk("ir_wr", 32'(wr_instruction), 1);
    chk("ir_wdata", 32'(wdata_instruction), 32'h220);
    chk("ir_ready_low", 32'(ready), 0);
    tick(1);
    chk("ir_work_2nd", 32'(work), 1);
    chk("ir_op", 32'(op), 0);
    wait_done(0, 100);
    chk("ir_n_wr", n_wr_ir, 1);
    chk("ir_n_work", n_work, 1);
    chk("ir_n_done", n_done, 1);
    chk("ir_err", n_err, 0);
    chk("ir_done_after_fall", done_cyc - fall_cyc, 1);
    chk("ir_done_after_work", done_cyc - work_cyc, 7);

    // IR then DR with a src_valid gap
    clear_mon();
    cmd(2'b10, 10'h155, 5'd3);
    fork
      begin
        src_send(8'hC4, 0);
        src_send(8'hA5, 2);
        src_send(8'h5A, 0);
        src_valid = 1'b0;
      end
      wait_done(0, 200);
    join
    chk("irdr_ir_val", 32'(last_ir), 32'h155);
    chk("irdr_n_ir", n_wr_ir, 1);
    chk("irdr_n_data", n_wr_data, 3);
    chk("irdr_d0", 32'(dr_log[0]), 32'hC4);
    chk("irdr_d1", 32'(dr_log[1]), 32'hA5);
    chk("irdr_d2", 32'(dr_log[2]), 32'h5A);
    chk("irdr_n_work", n_work, 2);
    chk("irdr_op0", 32'(op_at_work[0]), 0);
    chk("irdr_op1", 32'(op_at_work[1]), 1);
    chk("irdr_n_done", n_done, 1);
    chk("irdr_op_bad", n_op_bad, 0);
    chk("irdr_overlap", n_overlap, 0);

    // DR only, waits for FIFO space
    clear_mon();
    full_data = 1'b1; usedw_data = 4'd0;
    cmd(2'b01, 10'h0, 5'd4);
    tick(4);
    full_data = 1'b0; usedw_data = 4'd14;
    tick(3);
    usedw_data = 4'd13;
    tick(3);
    chk("space_src_ready_held", n_src_ready, 0);
    usedw_data = 4'd12;
    fork
      begin
        src_send(8'h11, 0);
        src_send(8'h22, 0);
        src_send(8'h33, 0);
        src_send(8'h44, 0);
        src_valid = 1'b0;
      end
      wait_done(0, 200);
    join
    usedw_data = 4'd0;
    chk("space_n_data", n_wr_data, 4);
    chk("space_d3", 32'(dr_log[3]), 32'h44);
    chk("space_d0", 32'(dr_log[0]), 32'h11);
    chk("space_n_work", n_work, 1);
    chk("space_work_after_wr", work_cyc - last_wrd_cyc, 1);
    chk("space_overlap", n_overlap, 0);
    chk("space_err", n_err, 0);

    // command errors: done+err the cycle after start
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      cmd(bad_mode[i], 10'h3FF, bad_dr[i]);
      chk($sformatf("bad%0d_done", i), 32'(done), 1);
      chk($sformatf("bad%0d_err", i), 32'(err), 1);
      tick(1);
      chk($sformatf("bad%0d_idle", i), {30'd0, ready, done}, 32'h2);
    end
    chk("bad_no_writes", n_wr_ir + n_wr_data + n_work, 0);

    // busy never rises
    clear_mon();
    eng_en = 1'b0;
    cmd(2'b00, 10'h0AA, 5'd0);
    wait_done(0, 400);
    eng_en = 1'b1;
    chk("tmo_err", n_err, 1);
    chk("tmo_latency", done_cyc - work_cyc, 256);
    chk("tmo_err_alone", n_err_alone, 0);

    // start pulses during ST_WR_DATA are ignored
    clear_mon();
    cmd(2'b01, 10'h0, 5'd4);
    fork
      begin
        src_send(8'h01, 0);
        src_send(8'h02, 3);
        src_send(8'h03, 3);
        src_send(8'h04, 3);
        src_valid = 1'b0;
      end
      begin
        tick(3);
        start = 1'b1; mode = 2'b00;
        tick(1);
        start = 1'b0;
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0; mode = 2'b01;
      end
      wait_done(0, 200);
    join
    tick(10);
    chk("ign_n_done", n_done, 1);
    chk("ign_n_work", n_work, 1);
    chk("ign_n_ir", n_wr_ir, 0);
    chk("ign_n_data", n_wr_data, 4);
    chk("ign_d3", 32'(dr_log[3]), 32'h04);

    // reset after 2 of 4 words
    clear_mon();
    cmd(2'b01, 10'h0, 5'd4);
    src_send(8'h77, 0);
    src_send(8'h88, 0);
    rst = 1'b1;
    src_valid = 1'b0;
    tick(1);
    chk("mid_rst_ready", 32'(ready), 1);
    chk("mid_rst_outs", {26'd0, done, err, op, work, wr_instruction, wr_data}, 0);
    chk("mid_rst_wdata", {14'd0, wdata_instruction, wdata_data}, 0);
    chk("mid_rst_src_ready", 32'(src_ready), 0);
    rst = 1'b0;
    tick(10);
    chk("mid_rst_no_done", n_done, 0);
    chk("mid_rst_no_work", n_work, 0);
    chk("mid_rst_n_data", n_wr_data, 2);
    chk("mid_rst_idle", 32'(ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_seq_ctrl.md
Name: jtag_seq_ctrl

Overview:
- Parametrised successor to the fixed-pattern JTAG stimulus FSM.
- Accepts a scan command (IR, DR or IR-then-DR) with a programmable instruction and a variable-length data burst streamed from an upstream source.
- Loads the instruction and data FIFOs feeding the JTAG shift engine, launches each scan via op/work, and tracks engine busy to completion, reporting done or error.

Parameters:
DATA_INSTRUCTION, 10, instruction word width
DATA_FIFO, 8, data word width
FIFO_DEPTH, 16, depth of both downstream FIFOs
MAX_WORDS, 16, max data words per DR scan; must be <= FIFO_DEPTH
BUSY_TIMEOUT, 255, max cycles from work pulse to busy rising

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
start  in  1  command strobe; sampled only in ST_IDLE
mode  in  2  00 IR only, 01 DR only, 10 IR then DR, 11 reserved
ir_value  in  DATA_INSTRUCTION  instruction to load
dr_words  in  $clog2(MAX_WORDS+1)  number of data words in DR burst
src_data  in  DATA_FIFO  upstream data word
src_valid  in  1  upstream word valid
src_ready  out  1  block accepts upstream word
ready  out  1  high in ST_IDLE
done  out  1  1-cycle completion pulse
err  out  1  1-cycle error flag, coincident with done
op  out  1  scan type to engine: 0 IR, 1 DR
work  out  1  1-cycle launch pulse to engine
busy  in  1  engine busy
wdata_instruction  out  DATA_INSTRUCTION  instruction FIFO write data
wr_instruction  out  1  instruction FIFO write strobe
full_instruction  in  1  instruction FIFO full
usedw_instruction  in  $clog2(FIFO_DEPTH)  instruction FIFO fill level (unused; kept for port symmetry)
wdata_data  out  DATA_FIFO  data FIFO write data
wr_data  out  1  data FIFO write strobe
full_data  in  1  data FIFO full
usedw_data  in  $clog2(FIFO_DEPTH)  data FIFO fill level

Behaviour:
- Single clock clk. Reset rst is synchronous, active high.
- Reset values:
  - ready = 1.
  - done, err, op, work, wr_instruction, wr_data = 0.
  - wdata_* = 0.
  - State ST_IDLE; latched command and counters cleared.
- Reset mid-operation aborts immediately with no done pulse. Words already written to the FIFOs stay there.
- States:
  - ST_IDLE: on start, latch mode, ir_value and dr_words.
    - Error case: mode == 11, or DR phase requested with dr_words == 0, or dr_words > MAX_WORDS. Go to ST_DONE with err = 1.
    - Otherwise, mode 00/10 -> ST_WR_IR; mode 01 -> ST_WAIT_SPACE.
  - ST_WR_IR: stall while full_instruction = 1. Otherwise assert wr_instruction for exactly 1 cycle with wdata_instruction = latched ir_value, set op = 0, go to ST_LAUNCH.
  - ST_WAIT_SPACE: free = full_data ? 0 : FIFO_DEPTH - usedw_data. Wait until free >= dr_words, so the whole burst fits before launch. Then set op = 1 and go to ST_WR_DATA with remaining = dr_words.
  - ST_WR_DATA:
    - src_ready = 1 (combinational) while remaining > 0.
    - On a src_valid && src_ready cycle, wr_data = 1 and wdata_data = src_data on the next cycle, and remaining decrements.
    - Gaps in src_valid insert idle cycles; wr_data returns to 0 between words.
    - The transfer that makes remaining reach 0 goes to ST_LAUNCH.
  - ST_LAUNCH: wait until busy = 0 and no FIFO strobe is active this cycle. Then pulse work for 1 cycle and go to ST_WAIT_BUSY. work never coincides with wr_data or wr_instruction.
  - ST_WAIT_BUSY:
    - Timeout counter starts at the work pulse.
    - busy rising -> ST_WAIT_DONE.
    - Counter reaching BUSY_TIMEOUT without busy -> ST_DONE with err = 1.
  - ST_WAIT_DONE: on busy falling:
    - If the latched mode is 10 and the IR phase just finished -> ST_WAIT_SPACE.
    - Otherwise -> ST_DONE.
  - ST_DONE: pulse done (plus err if flagged) for 1 cycle, then go to ST_IDLE.
- op holds its value for the whole phase and keeps its last value in ST_IDLE.
- start outside ST_IDLE is ignored, with no queuing.
- src_ready = 0 in every state except ST_WR_DATA.
- Fastest IR-only run with busy idle: ST_WR_IR (1 cycle), ST_LAUNCH with work at the 2nd cycle after start, then the engine time.

Test Plan:
- IR only: mode=00, ir_value=10'h220, engine busy 5 cycles -> one wr_instruction with 10'h220, op=0, single work pulse, done 1 cycle after busy falls, err=0.
- IR then DR: mode=10, dr_words=3, src words C4/A5/5A with a 2-cycle src_valid gap -> 1 IR write, IR launch, then 3 wr_data in order, op=1, second work pulse, exactly one done.
- Space wait: mode=01, dr_words=4, usedw_data=14 -> src_ready stays 0 until usedw_data <= 12, then 4 writes and launch.
- Errors: dr_words=0 with mode=01 -> done and err on the cycle after start, no FIFO writes. Busy never rising -> err after BUSY_TIMEOUT cycles.
- start pulses during ST_WR_DATA -> ignored, only one done.
- rst asserted after 2 of 4 data words -> all outputs at reset values on the next cycle, no done, ready = 1.
